// File: rtl/aes_core_top.sv
// Iterative AES-128 encryption core: one round per clk_sys-style clock, round keys
// expanded on the fly alongside the data path.

module aes_sbox (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);
  // Row 0 sits in the MSBs, so entry x starts at bit 8*(255-x) = {~x, 3'b000}.
  localparam logic [2047:0] LP_SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign o_byte = LP_SBOX[{~i_byte, 3'b000} +: 8];
endmodule

// State  | meaning
// S_IDLE | waiting for i_en; o_ready=1
// S_RUN  | one AES round per clock, round counter 1..last
module aes_core_top #(
  parameter int RND_SIZE = 128,
  parameter int WRD_SIZE = 32,
  parameter int NUM_BLK  = 4,
  parameter int MAX_CNT  = 10,
  parameter int CNT_SIZE = 4,
  parameter int NUM_RND  = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_en,
  input  logic [RND_SIZE-1:0] i_msg,
  input  logic [RND_SIZE-1:0] i_key,
  output logic                o_valid,
  output logic [RND_SIZE-1:0] o_cypher,
  output logic                o_ready,
  output logic                busy
);
  localparam int LP_NBYTES = RND_SIZE / 8;
  localparam logic [CNT_SIZE-1:0] LP_LAST =
    CNT_SIZE'((NUM_RND < MAX_CNT) ? NUM_RND : MAX_CNT);
  localparam logic S_IDLE = 1'b0;
  localparam logic S_RUN  = 1'b1;

  logic                r_fsm;
  logic [RND_SIZE-1:0] r_state;
  logic [RND_SIZE-1:0] r_key;
  logic [CNT_SIZE-1:0] r_cnt;
  logic                r_valid;
  logic [RND_SIZE-1:0] r_cypher;

  logic [7:0]          w_sb [LP_NBYTES];
  logic [7:0]          w_sr [LP_NBYTES];
  logic [WRD_SIZE-1:0] w_w3;
  logic [WRD_SIZE-1:0] w_rot;
  logic [7:0]          w_ksub [4];
  logic [WRD_SIZE-1:0] w_temp;
  logic [RND_SIZE-1:0] w_rk;
  logic [RND_SIZE-1:0] w_next_state;
  logic                w_last;

  function automatic logic [7:0] f_xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] f_mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {f_xtime(a0) ^ f_xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ f_xtime(a1) ^ f_xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ f_xtime(a2) ^ f_xtime(a3) ^ a3,
            f_xtime(a0) ^ a0 ^ a1 ^ a2 ^ f_xtime(a3)};
  endfunction

  function automatic logic [7:0] f_rcon(input logic [CNT_SIZE-1:0] cnt);
    case (int'(cnt))
      1:       return 8'h01;
      2:       return 8'h02;
      3:       return 8'h04;
      4:       return 8'h08;
      5:       return 8'h10;
      6:       return 8'h20;
      7:       return 8'h40;
      8:       return 8'h80;
      9:       return 8'h1b;
      10:      return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  genvar g;
  generate
    for (g = 0; g < LP_NBYTES; g++) begin : g_state_sbox
      aes_sbox u_sbox (.i_byte(r_state[RND_SIZE-1-8*g -: 8]), .o_byte(w_sb[g]));
    end
    for (g = 0; g < 4; g++) begin : g_key_sbox
      aes_sbox u_sbox (.i_byte(w_rot[WRD_SIZE-1-8*g -: 8]), .o_byte(w_ksub[g]));
    end
  endgenerate

  // Key schedule: RotWord/SubWord/Rcon on the last word, then the running XOR chain.
  assign w_w3   = r_key[WRD_SIZE-1:0];
  assign w_rot  = {w_w3[WRD_SIZE-9:0], w_w3[WRD_SIZE-1 -: 8]};
  assign w_temp = {w_ksub[0] ^ f_rcon(r_cnt), w_ksub[1], w_ksub[2], w_ksub[3]};
  assign w_rk[127:96] = r_key[127:96] ^ w_temp;
  assign w_rk[95:64]  = r_key[95:64]  ^ w_rk[127:96];
  assign w_rk[63:32]  = r_key[63:32]  ^ w_rk[95:64];
  assign w_rk[31:0]   = r_key[31:0]   ^ w_rk[63:32];

  assign w_last = (r_cnt == LP_LAST);

  // Byte (row r, column c) after ShiftRows comes from column (c + r) mod 4.
  always_comb begin
    for (int i = 0; i < LP_NBYTES; i++) begin
      w_sr[i] = w_sb[4 * (((i / 4) + (i % 4)) % NUM_BLK) + (i % 4)];
    end
  end

  always_comb begin
    w_next_state = '0;
    for (int c = 0; c < NUM_BLK; c++) begin
      logic [31:0] col;
      col = {w_sr[4*c], w_sr[4*c+1], w_sr[4*c+2], w_sr[4*c+3]};
      if (!w_last) col = f_mix_col(col);
      w_next_state[RND_SIZE-1-WRD_SIZE*c -: WRD_SIZE] =
        col ^ w_rk[RND_SIZE-1-WRD_SIZE*c -: WRD_SIZE];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm    <= S_IDLE;
      r_state  <= '0;
      r_key    <= '0;
      r_cnt    <= '0;
      r_valid  <= 1'b0;
      r_cypher <= '0;
    end else begin
      r_valid <= 1'b0;
      case (r_fsm)
        S_IDLE: begin
          if (i_en) begin
            r_state <= i_msg ^ i_key;
            r_key   <= i_key;
            r_cnt   <= CNT_SIZE'(1);
            r_fsm   <= S_RUN;
          end
        end
        S_RUN: begin
          r_state <= w_next_state;
          r_key   <= w_rk;
          if (w_last) begin
            r_cypher <= w_next_state;
            r_valid  <= 1'b1;
            r_cnt    <= '0;
            r_fsm    <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_SIZE'(1);
          end
        end
        default: r_fsm <= S_IDLE;
      endcase
    end
  end

  assign busy     = (r_fsm == S_RUN);
  assign o_ready  = ~busy;
  assign o_valid  = r_valid;
  assign o_cypher = r_cypher;
endmodule

// File: tb/tb_aes_core_top.sv
// Bench for aes_core_top: textbook AES-128 reference model (S-box derived from GF(2^8)
// inverse + affine map), cycle-level expectation of handshake timing, FIPS-197 vectors.
module tb_aes_core_top;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         i_en = 1'b0;
  logic [127:0] i_msg = '0;
  logic [127:0] i_key = '0;
  logic         o_valid;
  logic [127:0] o_cypher;
  logic         o_ready;
  logic         busy;

  int n_err = 0;
  int n_chk = 0;

  always #5 clk = ~clk;

  aes_core_top dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_en    (i_en),
    .i_msg   (i_msg),
    .i_key   (i_key),
    .o_valid (o_valid),
    .o_cypher(o_cypher),
    .o_ready (o_ready),
    .busy    (busy)
  );

  logic [7:0] sbox_m [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] aes_model(input logic [127:0] key, input logic [127:0] msg);
    logic [7:0] s [16];
    logic [7:0] k [16];
    logic [7:0] t [16];
    logic [7:0] tw [4];
    logic [7:0] rc, a0, a1, a2, a3;
    logic [127:0] res;
    for (int i = 0; i < 16; i++) begin
      k[i] = key[127-8*i -: 8];
      s[i] = msg[127-8*i -: 8] ^ k[i];
    end
    rc = 8'h01;
    for (int rnd = 1; rnd <= 10; rnd++) begin
      tw[0] = sbox_m[k[13]] ^ rc;
      tw[1] = sbox_m[k[14]];
      tw[2] = sbox_m[k[15]];
      tw[3] = sbox_m[k[12]];
      for (int j = 0; j < 16; j++) k[j] = k[j] ^ ((j < 4) ? tw[j] : k[j-4]);
      for (int i = 0; i < 16; i++) t[i] = sbox_m[s[4 * (((i / 4) + (i % 4)) % 4) + (i % 4)]];
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        if (rnd < 10) begin
          s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end else begin
          s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
        end
        for (int r = 0; r < 4; r++) s[4*c+r] = s[4*c+r] ^ k[4*c+r];
      end
      rc = gmul(rc, 8'h02);
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected behaviour: accept when idle, result 10 edges later, then idle again.
  logic         m_busy = 1'b0;
  logic         m_valid = 1'b0;
  logic [127:0] m_cypher = '0;
  logic [127:0] m_pending = '0;
  int           m_left = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy   <= 1'b0;
      m_valid  <= 1'b0;
      m_cypher <= '0;
      m_left   <= 0;
    end else begin
      m_valid <= 1'b0;
      if (m_busy) begin
        if (m_left == 1) begin
          m_busy   <= 1'b0;
          m_valid  <= 1'b1;
          m_cypher <= m_pending;
        end
        m_left <= m_left - 1;
      end else if (i_en) begin
        m_busy    <= 1'b1;
        m_left    <= 10;
        m_pending <= aes_model(i_key, i_msg);
      end
    end
  end

  always @(negedge clk) begin
    chk("cyc_valid", 128'(o_valid), 128'(m_valid));
    chk("cyc_busy", 128'(busy), 128'(m_busy));
    chk("cyc_ready", 128'(o_ready), 128'(!m_busy));
    chk("cyc_cypher", o_cypher, m_cypher);
  end

  task automatic run_block(input logic [127:0] key, input logic [127:0] msg,
                           input logic [127:0] exp, input string name);
    int n;
    bit seen;
    i_key = key;
    i_msg = msg;
    i_en  = 1'b1;
    @(posedge clk); #2;
    i_en  = 1'b0;
    i_key = ~key;
    i_msg = {$urandom, $urandom, $urandom, $urandom};
    n = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin
      @(posedge clk); #2;
      n++;
      if (n < 9) i_en = 1'($urandom_range(0, 1));
      else i_en = 1'b0;
      @(negedge clk);
      if (o_valid) seen = 1'b1;
    end
    chk({name, "_latency"}, 128'(n), 128'(10));
    chk({name, "_cypher"}, o_cypher, exp);
  endtask

  initial begin
    int pulses;
    build_sbox();

    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 128'(o_valid), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_ready", 128'(o_ready), 128'(1));
    chk("rst_cypher", o_cypher, 128'h0);

    chk("model_zero", aes_model(128'h0, 128'h0), 128'h66e94bd4ef8a2c3b884cfa59ca342b2e);
    chk("model_c1", aes_model(128'h000102030405060708090a0b0c0d0e0f,
                              128'h00112233445566778899aabbccddeeff),
        128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    chk("model_b1", aes_model(128'h2b7e151628aed2a6abf7158809cf4f3c,
                              128'h3243f6a8885a308d313198a2e0370734),
        128'h3925841d02dc09fbdc118597196a0b32);

    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #2;

    run_block(128'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, "vec_zero");
    run_block(128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff,
              128'h69c4e0d86a7b0430d8cdb78070b4c55a, "vec_c1");
    run_block(128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3243f6a8885a308d313198a2e0370734,
              128'h3925841d02dc09fbdc118597196a0b32, "vec_b1");

    // i_en held high, message changing every cycle: results at edges 10, 21, 32.
    @(posedge clk); #2;
    i_key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    i_msg = 128'h3243f6a8885a308d313198a2e0370734;
    i_en  = 1'b1;
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #2;
      i_msg = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      if (o_valid) pulses++;
      if (k == 10) chk("b2b_first", o_cypher, 128'h3925841d02dc09fbdc118597196a0b32);
    end
    chk("b2b_pulses", 128'(pulses), 128'(3));
    @(posedge clk); #2;
    i_en = 1'b0;
    repeat (15) @(posedge clk);
    #2;

    // Reset during round 5 aborts the block.
    i_key = 128'h000102030405060708090a0b0c0d0e0f;
    i_msg = 128'h00112233445566778899aabbccddeeff;
    i_en  = 1'b1;
    @(posedge clk); #2;
    i_en = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_valid", 128'(o_valid), 128'(0));
    chk("abort_busy", 128'(busy), 128'(0));
    chk("abort_ready", 128'(o_ready), 128'(1));
    chk("abort_cypher", o_cypher, 128'h0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (o_valid) pulses++;
    end
    chk("abort_no_valid", 128'(pulses), 128'(0));
    @(posedge clk); #2;
    run_block(128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff,
              128'h69c4e0d86a7b0430d8cdb78070b4c55a, "post_rst");

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
